// File: rtl/neuron_pkg.sv
// Shared constants and FSM state type for the neuron weight-update block.
package neuron_pkg;

  localparam int N_DEF    = 3;
  localparam int SIZE_DEF = 4;
  localparam int LANE_W   = SIZE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UPDATE = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/neuron_lane_upd.sv
// Single-lane weight update: w' = w + ((delta * s) >>> SHIFT), wrapped or saturated.
// Saturation is selected by defining NEURON_LEARN_SAT_EN.
module neuron_lane_upd
  import neuron_pkg::*;
#(
  parameter int SIZE  = LANE_W,
  parameter int SHIFT = 0
) (
  input  logic [SIZE-1:0] s_i,
  input  logic [SIZE-1:0] w_i,
  input  logic [SIZE-1:0] delta_i,
  output logic [SIZE-1:0] w_o
);

  localparam int PW = 2 * SIZE;
  localparam int SW = 2 * SIZE + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] inc;
  logic signed [SW-1:0] sum;

  always_comb begin
    prod = $signed({{SIZE{delta_i[SIZE-1]}}, delta_i}) * $signed({{SIZE{s_i[SIZE-1]}}, s_i});
    inc  = prod >>> SHIFT;
    // one guard bit above the product keeps the add exact before wrap/saturate
    sum  = $signed({inc[PW-1], inc}) + $signed({{(SW - SIZE){w_i[SIZE-1]}}, w_i});
`ifdef NEURON_LEARN_SAT_EN
    if (sum > $signed(SW'((1 << (SIZE - 1)) - 1))) begin
      w_o = {1'b0, {(SIZE - 1){1'b1}}};
    end else if (sum < -$signed(SW'(1 << (SIZE - 1)))) begin
      w_o = {1'b1, {(SIZE - 1){1'b0}}};
    end else begin
      w_o = sum[SIZE-1:0];
    end
`else
    w_o = sum[SIZE-1:0];
`endif
  end

endmodule

// File: rtl/neuron_learn.sv
// Perceptron-style weight updater: one lane per cycle through a shared lane unit.
// Build option NEURON_LEARN_SAT_EN saturates updated weights instead of wrapping.
module neuron_learn
  import neuron_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SIZE  = SIZE_DEF,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE*N-1:0] Scurr,
  input  logic [SIZE*N-1:0] W_in,
  input  logic [SIZE-1:0]   Snext,
  input  logic [SIZE-1:0]   target,
  output logic [SIZE*N-1:0] W_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W     = SIZE * N;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  lane_q, lane_d;
  logic [W-1:0]      s_q, s_d, w_q, w_d, w_out_q, w_out_d;
  logic [SIZE-1:0]   delta_q, delta_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [SIZE-1:0]   delta_new, lane_s, lane_w, lane_w_new;

  assign delta_new = target - Snext;
  assign lane_s    = s_q[SIZE*lane_q +: SIZE];
  assign lane_w    = w_q[SIZE*lane_q +: SIZE];

  neuron_lane_upd #(.SIZE(SIZE), .SHIFT(SHIFT)) u_lane (
    .s_i     (lane_s),
    .w_i     (lane_w),
    .delta_i (delta_q),
    .w_o     (lane_w_new)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    s_d     = s_q;
    w_d     = w_q;
    delta_d = delta_q;
    w_out_d = w_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = Scurr;
          w_d     = W_in;
          delta_d = delta_new;
          busy_d  = 1'b1;
          lane_d  = '0;
          if (delta_new != '0) begin
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_DONE;
            w_out_d = W_in;
            err_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        w_d[SIZE*lane_q +: SIZE] = lane_w_new;
        if (lane_q == CNT_W'(N - 1)) begin
          state_d = ST_DONE;
          lane_d  = '0;
          w_out_d = w_d;
          err_d   = (delta_q != '0);
          done_d  = 1'b1;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        lane_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      s_q     <= '0;
      w_q     <= '0;
      delta_q <= '0;
      w_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      s_q     <= s_d;
      w_q     <= w_d;
      delta_q <= delta_d;
      w_out_q <= w_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign W_out = w_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_neuron_learn.sv
// Directed bench for neuron_learn (N=3, SIZE=4, SHIFT=0) with immediate assertions.
module tb_neuron_learn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] Scurr = '0;
  logic [11:0] W_in = '0;
  logic [3:0]  Snext = '0;
  logic [3:0]  target = '0;
  logic [11:0] W_out;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;

`ifdef NEURON_LEARN_SAT_EN
  localparam logic [11:0] EXP_POS = 12'h467;
  localparam logic [11:0] EXP_EDG = 12'h047;
`else
  localparam logic [11:0] EXP_POS = 12'h468;
  localparam logic [11:0] EXP_EDG = 12'h04E;
`endif

  neuron_learn #(.N(3), .SIZE(4), .SHIFT(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .Scurr  (Scurr),
    .W_in   (W_in),
    .Snext  (Snext),
    .target (target),
    .W_out  (W_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after done has dropped.
  task automatic run_pass(input string tag, input logic [11:0] s, input logic [11:0] w,
                          input logic [3:0] tg, input logic [3:0] sn, input int exp_edges,
                          input logic [11:0] exp_w, input logic exp_err);
    int n;
    Scurr = s; W_in = w; target = tg; Snext = sn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Scurr = ~s; W_in = ~w; target = ~tg; Snext = ~sn;
    check({tag, ".busy_at_edge1"}, {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, exp_edges);
    check({tag, ".w_out"}, {20'd0, W_out}, {20'd0, exp_w});
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, ".w_out_held"}, {20'd0, W_out}, {20'd0, exp_w});
    check({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    #3;
    check("reset.w_out", {20'd0, W_out}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass("pos", 12'h123, 12'h222, 4'h1, 4'hF, 4, EXP_POS, 1'b1);
    run_pass("neg", 12'h123, 12'h222, 4'hF, 4'h1, 4, 12'h0EC, 1'b1);
    run_pass("noerr", 12'h123, 12'h222, 4'h1, 4'h1, 1, 12'h222, 1'b0);
    run_pass("noerr2", 12'h5A7, 12'h93C, 4'hF, 4'hF, 1, 12'h93C, 1'b0);
    run_pass("edge", 12'hF17, 12'h137, 4'h1, 4'h0, 4, EXP_EDG, 1'b1);
    run_pass("b2b", 12'h123, 12'h222, 4'h1, 4'hF, 4, EXP_POS, 1'b1);

    // start held high across two passes
    Scurr = 12'h123; W_in = 12'h222; target = 4'hF; Snext = 4'h1; start = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) cnt++;
      if (i == 5) begin
        check("held.busy_gap", {31'd0, busy}, 32'd0);
        check("held.done_gap", {31'd0, done}, 32'd0);
      end
      if (i == 6) check("held.busy_restart", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    check("held.done_count", cnt, 2);
    check("held.w_out", {20'd0, W_out}, 32'h0EC);
    @(negedge clk);
    check("held.idle", {31'd0, busy}, 32'd0);

    // reset during lane 1 of a pass
    Scurr = 12'h123; W_in = 12'h222; target = 4'h1; Snext = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.w_out", {20'd0, W_out}, 32'd0);
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check("midrst.done", {31'd0, done}, 32'd0);
    check("midrst.err", {31'd0, err}, 32'd0);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("midrst.no_done", cnt, 0);
    run_pass("after_rst", 12'h123, 12'h222, 4'h1, 4'hF, 4, EXP_POS, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_learn.md
NEURON_LEARN -- requirements
Module: neuron_learn

Interface
REQ-001 Parameter N, default 3: number of inputs and weights per neuron.
REQ-002 Parameter SIZE, default 4: bit width of each state, weight and output, two's complement.
REQ-003 Parameter SHIFT, default 0: learning rate, applied as an arithmetic right shift of each weight increment.
REQ-004 Port clk, input, 1 bit: single clock; all registers update on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start, input, 1 bit: request one weight-update pass; sampled only in IDLE.
REQ-007 Port Scurr, input, SIZE*N bits: neuron input states; lane k occupies bits [SIZE*k +: SIZE], so lane 0 is at the LSBs.
REQ-008 Port W_in, input, SIZE*N bits: current weights, same lane packing as Scurr.
REQ-009 Port Snext, input, SIZE bits: actual neuron output, one of 0, 1 or -1 (all ones).
REQ-010 Port target, input, SIZE bits: desired neuron output.
REQ-011 Port W_out, output, SIZE*N bits: updated weights, registered, held until the next done.
REQ-012 Port busy, output, 1 bit: high while a pass is in progress.
REQ-013 Port done, output, 1 bit: one-cycle pulse marking the edge at which W_out became valid.
REQ-014 Port err, output, 1 bit: registered (target != Snext) of the last pass, valid from done onward.

Function
REQ-015 The block shall implement an FSM with states IDLE, UPDATE and DONE.
REQ-016 In IDLE, start=1 shall capture Scurr and W_in, compute delta = target - Snext (SIZE-bit, wrapping) and set busy=1.
- delta != 0: go to UPDATE with the lane counter at 0.
- delta == 0: go directly to DONE.
REQ-017 UPDATE shall process one lane per cycle, lanes 0 to N-1, then go to DONE.
- inc = (delta * S_k) >>> SHIFT, computed as a signed 2*SIZE product.
- W_k' = sign-extended W_k + inc, reduced to SIZE bits by wrap-around truncation.
REQ-018 DONE shall last one cycle: done=1, W_out and err registered, busy=0; next state is IDLE.
REQ-019 Latency, counted from the edge that samples start:
- delta != 0: done high after edge N+1.
- delta == 0: done high after edge 1, with W_out = W_in and err=0.
REQ-020 start shall be ignored while busy=1, including while in DONE; Scurr, W_in, Snext and target may change freely after capture.
REQ-021 A start asserted on the cycle after done shall be accepted normally, giving back-to-back passes.
REQ-022 An undefined state encoding shall recover to IDLE.

Reset
REQ-023 rst_n low shall immediately force IDLE and clear the lane counter, W_out, busy, done, err and all capture registers to 0.
REQ-024 Reset asserted mid-pass shall abort the pass with no done pulse; the first start after release shall run a complete pass.

Configuration
REQ-025 Macro NEURON_LEARN_SAT_EN.
- Defined: each W_k' saturates to the range [-2^(SIZE-1), 2^(SIZE-1)-1].
- Undefined: W_k' wraps (REQ-017). All other behaviour is identical in both builds.

Structure
REQ-026 Package neuron_pkg shall hold:
- the default N and SIZE constants, shared with the neuron;
- the FSM state typedef;
- a lane-slice width constant.
REQ-027 The per-lane arithmetic (multiply, shift, add, wrap or saturate) shall live in combinational sub-module neuron_lane_upd, instantiated once and muxed by the lane counter.

Verification (N=3, SIZE=4, SHIFT=0; Scurr=12'h123, so lanes 0/1/2 = 3/2/1; W_in=12'h222)
REQ-028 Positive update: target=4'h1, Snext=4'hF, giving delta=2.
- Without the macro: done after edge 4, W_out=12'h468, err=1.
- With NEURON_LEARN_SAT_EN: W_out=12'h467.
REQ-029 Negative update: target=4'hF, Snext=4'h1, giving delta=-2 -> done after edge 4, W_out=12'h0EC, err=1.
REQ-030 No error: target=Snext=4'h1 -> done after edge 1, W_out=12'h222, err=0, busy high for exactly 1 cycle.
REQ-031 start held high through a whole pass -> exactly one done per pass; no second pass begins until the cycle after done.
REQ-032 rst_n pulsed low during UPDATE lane 1 -> W_out, busy, done and err read 0 at once; a following start with the REQ-028 stimulus yields 12'h468.
